flash_loader: RTL and testbench

- Upstream feeder of the CPU program memory.
- Receives a framed program image over a UART RX line, assembles little-endian 16-bit words and writes them into the 16-bit flash word array that drives the CPU `ir`.
- Holds the CPU halted through its `locked` input while a download is in progress.
- Releases the CPU after a frame with a good checksum, so firmware can be reloaded without resynthesis.

---
 rtl/flash_loader_pkg.sv | 27 ++
 rtl/flash_loader_if.sv | 22 ++
 rtl/flash_loader_uart_rx.sv | 89 ++++++++
 rtl/flash_loader.sv | 125 ++++++++++++
 tb/tb_flash_loader.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_loader_pkg.sv
// Shared types and constants for the UART flash loader.
// Holds the frame FSM encoding, the sync byte and the baud divider helper.
package flash_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_L  = 3'd1,
        ST_LEN_H  = 3'd2,
        ST_DATA_L = 3'd3,
        ST_DATA_H = 3'd4,
        ST_CSUM   = 3'd5
    } fl_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/flash_loader_if.sv
// Loader-side bundle: UART line in, flash write port and CPU/status flags out.
interface flash_loader_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              rx;
    logic [ADDR_W-1:0] fl_address;
    logic [15:0]       fl_data;
    logic              fl_w;
    logic              cpu_run;
    logic              busy;
    logic              err;

    modport master (
        input  rx,
        output fl_address, fl_data, fl_w, cpu_run, busy, err
    );

    modport slave (
        output rx,
        input  fl_address, fl_data, fl_w, cpu_run, busy, err
    );
endinterface

// File: rtl/flash_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, false-start rejection.
module flash_loader_uart_rx
    import flash_loader_pkg::*;
#(
    parameter int unsigned DIV = 217
) (
    input  logic       clock,
    input  logic       locked,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_frame_err
);

    localparam int unsigned CNT_W = $clog2(DIV + 1);
    localparam int unsigned HALF  = DIV / 2;

    logic             r_meta;
    logic             r_sync;
    logic             r_prev;
    rx_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_valid;
    logic             r_ferr;

    always_ff @(posedge clock or negedge locked) begin
        if (!locked) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_meta  <= i_rx;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (r_prev && !r_sync) r_state <= RX_START;
                end
                // Line must still be low half a bit later, otherwise it was a glitch
                RX_START: begin
                    if (r_cnt == CNT_W'(HALF - 1)) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= r_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_cnt == CNT_W'(DIV - 1)) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_state <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_cnt == CNT_W'(DIV - 1)) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (r_sync) r_valid <= 1'b1;
                        else        r_ferr  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign o_byte      = r_shift;
    assign o_valid     = r_valid;
    assign o_frame_err = r_ferr;

endmodule

// File: rtl/flash_loader.sv
// Frame decoder that streams a UART program image into flash words and
// holds the CPU halted until a frame with a matching checksum completes.
module flash_loader
    import flash_loader_pkg::*;
#(
    parameter int unsigned CLK_HZ = 25000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned ADDR_W = 12
) (
    input  logic           clock,
    input  logic           locked,
    flash_loader_if.master bus
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);

    logic [7:0] w_byte;
    logic       w_valid;
    logic       w_ferr;

    flash_loader_uart_rx #(.DIV(DIV)) u_rx (
        .clock       (clock),
        .locked      (locked),
        .i_rx        (bus.rx),
        .o_byte      (w_byte),
        .o_valid     (w_valid),
        .o_frame_err (w_ferr)
    );

    fl_state_e         r_state;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_len;
    logic [15:0]       r_count;
    logic [ADDR_W-1:0] r_index;
    logic [7:0]        r_low;
    logic [7:0]        r_sum;
    logic [ADDR_W-1:0] r_fl_address;
    logic [15:0]       r_fl_data;
    logic              r_fl_w;
    logic              r_cpu_run;
    logic              r_busy;
    logic              r_err;

    always_ff @(posedge clock or negedge locked) begin
        if (!locked) begin
            r_state      <= ST_IDLE;
            r_len_lo     <= '0;
            r_len        <= '0;
            r_count      <= '0;
            r_index      <= '0;
            r_low        <= '0;
            r_sum        <= '0;
            r_fl_address <= '0;
            r_fl_data    <= '0;
            r_fl_w       <= 1'b0;
            r_cpu_run    <= 1'b1;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_fl_w <= 1'b0;
            if (w_ferr) begin
                if (r_state != ST_IDLE) begin
                    r_err   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            end else if (w_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_byte == SYNC_BYTE) begin
                            r_cpu_run <= 1'b0;
                            r_err     <= 1'b0;
                            r_sum     <= '0;
                            r_index   <= '0;
                            r_count   <= '0;
                            r_busy    <= 1'b1;
                            r_state   <= ST_LEN_L;
                        end
                    end
                    ST_LEN_L: begin
                        r_len_lo <= w_byte;
                        r_state  <= ST_LEN_H;
                    end
                    ST_LEN_H: begin
                        r_len   <= {w_byte, r_len_lo};
                        r_state <= ({w_byte, r_len_lo} == 16'd0) ? ST_CSUM : ST_DATA_L;
                    end
                    ST_DATA_L: begin
                        r_low   <= w_byte;
                        r_sum   <= r_sum + w_byte;
                        r_state <= ST_DATA_H;
                    end
                    // Index wraps at the flash size; the 16-bit count tracks frame length
                    ST_DATA_H: begin
                        r_sum        <= r_sum + w_byte;
                        r_fl_data    <= {w_byte, r_low};
                        r_fl_address <= r_index;
                        r_fl_w       <= 1'b1;
                        r_index      <= r_index + ADDR_W'(1);
                        r_count      <= r_count + 16'd1;
                        r_state      <= ((r_count + 16'd1) == r_len) ? ST_CSUM : ST_DATA_L;
                    end
                    ST_CSUM: begin
                        if (w_byte == r_sum) r_cpu_run <= 1'b1;
                        else                 r_err     <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.fl_address = r_fl_address;
    assign bus.fl_data    = r_fl_data;
    assign bus.fl_w       = r_fl_w;
    assign bus.cpu_run    = r_cpu_run;
    assign bus.busy       = r_busy;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_flash_loader.sv
// Scoreboarded bench for flash_loader: UART frames in, flash writes and CPU gating out.
module tb_flash_loader;

    localparam int unsigned CLK_HZ = 1600000;
    localparam int unsigned BAUD   = 100000;
    localparam int unsigned DIV    = CLK_HZ / BAUD;

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] data;
        logic [31:0] lat;
    } wr_t;

    logic clk = 1'b0;
    logic locked;

    flash_loader_if #(.ADDR_W(12)) bus ();

    flash_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(12)) dut (
        .clock  (clk),
        .locked (locked),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  n_total = 0;
    int  n_pass  = 0;
    int  cyc     = 0;
    int  last_v  = 0;
    int  n_valid = 0;
    wr_t mon_w;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write with its distance from the last received byte
    always @(negedge clk) begin
        if (dut.u_rx.o_valid) begin
            last_v  = cyc;
            n_valid = n_valid + 1;
        end
        if (bus.fl_w) begin
            mon_w.addr = bus.fl_address;
            mon_w.data = bus.fl_data;
            mon_w.lat  = 32'(cyc - last_v);
            obs_q.push_back(mon_w);
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus.rx = 1'b0;
        wait_clks(DIV);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            wait_clks(DIV);
        end
        bus.rx = stop_bit;
        wait_clks(DIV);
        bus.rx = 1'b1;
        wait_clks(2 * DIV);
    endtask

    task automatic send_frame(input int n, input logic [15:0] w0, input logic [15:0] w1,
                              input logic corrupt);
        logic [7:0]  s;
        logic [15:0] w;
        logic [15:0] nn;
        wr_t         e;
        s  = 8'h00;
        nn = 16'(n);
        send_byte(8'hA5, 1'b1);
        send_byte(nn[7:0], 1'b1);
        send_byte(nn[15:8], 1'b1);
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? w0 : w1;
            e.addr = 12'(i);
            e.data = w;
            e.lat  = 32'd1;
            exp_q.push_back(e);
            send_byte(w[7:0], 1'b1);
            send_byte(w[15:8], 1'b1);
            s = s + w[7:0] + w[15:8];
        end
        send_byte(corrupt ? 8'h00 : s, 1'b1);
    endtask

    task automatic test_reset;
        locked = 1'b0;
        bus.rx = 1'b1;
        wait_clks(3);
        n_total++; if (bus.cpu_run !== 1'b1) $display("FAIL reset_cpu_run: got %b want 1", bus.cpu_run); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err); else n_pass++;
        n_total++; if (bus.fl_w !== 1'b0) $display("FAIL reset_fl_w: got %b want 0", bus.fl_w); else n_pass++;
        n_total++; if (bus.fl_address !== 12'h000 || bus.fl_data !== 16'h0000)
            $display("FAIL reset_fl_bus: got %h/%h want 000/0000", bus.fl_address, bus.fl_data); else n_pass++;
        locked = 1'b1;
        wait_clks(1000);
        n_total++; if (bus.cpu_run !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL idle_state: got run=%b busy=%b want 1/0", bus.cpu_run, bus.busy); else n_pass++;
        n_total++; if (obs_q.size() != 0) $display("FAIL idle_writes: got %0d want 0", obs_q.size()); else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_good_frame;
        wr_t e;
        wr_t o;
        e.lat = 32'd1;
        e.addr = 12'h000; e.data = 16'h1234; exp_q.push_back(e);
        e.addr = 12'h001; e.data = 16'hABCD; exp_q.push_back(e);
        send_byte(8'hA5, 1'b1);
        n_total++; if (bus.cpu_run !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL good_sync: got run=%b busy=%b want 0/1", bus.cpu_run, bus.busy); else n_pass++;
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
        send_byte(8'hCD, 1'b1); send_byte(8'hAB, 1'b1);
        n_total++; if (bus.cpu_run !== 1'b0) $display("FAIL good_pre_csum_run: got %b want 0", bus.cpu_run); else n_pass++;
        send_byte(8'hBE, 1'b1);
        n_total++; if (bus.cpu_run !== 1'b1 || bus.err !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL good_end: got run=%b err=%b busy=%b want 1/0/0", bus.cpu_run, bus.err, bus.busy); else n_pass++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) $display("FAIL good_write: got none want %h@%h", e.data, e.addr);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL good_write: got %h@%h lat %0d want %h@%h lat %0d",
                                      o.data, o.addr, o.lat, e.data, e.addr, e.lat);
                else n_pass++;
            end
        end
        n_total++; if (obs_q.size() != 0) $display("FAIL good_extra: got %0d extra writes want 0", obs_q.size()); else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_bad_csum;
        wr_t e;
        wr_t o;
        send_frame(2, 16'h1234, 16'hABCD, 1'b1);
        n_total++; if (bus.err !== 1'b1 || bus.cpu_run !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL bad_csum: got err=%b run=%b busy=%b want 1/0/0", bus.err, bus.cpu_run, bus.busy); else n_pass++;
        send_frame(2, 16'h0001, 16'hFFFF, 1'b0);
        n_total++; if (bus.err !== 1'b0 || bus.cpu_run !== 1'b1)
            $display("FAIL recover: got err=%b run=%b want 0/1", bus.err, bus.cpu_run); else n_pass++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) $display("FAIL csum_write: got none want %h@%h", e.data, e.addr);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL csum_write: got %h@%h lat %0d want %h@%h lat %0d",
                                      o.data, o.addr, o.lat, e.data, e.addr, e.lat);
                else n_pass++;
            end
        end
        n_total++; if (obs_q.size() != 0) $display("FAIL csum_extra: got %0d extra writes want 0", obs_q.size()); else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_empty_and_noise;
        send_frame(0, 16'h0000, 16'h0000, 1'b0);
        n_total++; if (bus.cpu_run !== 1'b1 || bus.err !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL empty_frame: got run=%b err=%b busy=%b want 1/0/0", bus.cpu_run, bus.err, bus.busy); else n_pass++;
        send_byte(8'h55, 1'b1);
        n_total++; if (bus.cpu_run !== 1'b1 || bus.busy !== 1'b0 || bus.err !== 1'b0)
            $display("FAIL idle_noise: got run=%b busy=%b err=%b want 1/0/0", bus.cpu_run, bus.busy, bus.err); else n_pass++;
        n_total++; if (obs_q.size() != 0) $display("FAIL empty_writes: got %0d want 0", obs_q.size()); else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_a5_data;
        wr_t e;
        wr_t o;
        send_frame(1, 16'hA5A5, 16'h0000, 1'b0);
        n_total++; if (bus.cpu_run !== 1'b1 || bus.err !== 1'b0)
            $display("FAIL a5_data_end: got run=%b err=%b want 1/0", bus.cpu_run, bus.err); else n_pass++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) $display("FAIL a5_write: got none want %h@%h", e.data, e.addr);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL a5_write: got %h@%h lat %0d want %h@%h lat %0d",
                                      o.data, o.addr, o.lat, e.data, e.addr, e.lat);
                else n_pass++;
            end
        end
        n_total++; if (obs_q.size() != 0) $display("FAIL a5_extra: got %0d extra writes want 0", obs_q.size()); else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_framing_err;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h34, 1'b0);
        n_total++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.cpu_run !== 1'b0)
            $display("FAIL framing: got err=%b busy=%b run=%b want 1/0/0", bus.err, bus.busy, bus.cpu_run); else n_pass++;
        send_byte(8'h12, 1'b1);
        n_total++; if (bus.busy !== 1'b0 || obs_q.size() != 0)
            $display("FAIL framing_after: got busy=%b writes=%0d want 0/0", bus.busy, obs_q.size()); else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_glitch;
        int v0;
        v0 = n_valid;
        bus.rx = 1'b0;
        wait_clks(DIV / 4);
        bus.rx = 1'b1;
        wait_clks(3 * DIV);
        n_total++; if (n_valid != v0) $display("FAIL glitch_bytes: got %0d bytes want 0", n_valid - v0); else n_pass++;
        n_total++; if (bus.busy !== 1'b0 || bus.err !== 1'b1 || bus.cpu_run !== 1'b0)
            $display("FAIL glitch_state: got busy=%b err=%b run=%b want 0/1/0", bus.busy, bus.err, bus.cpu_run); else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        wr_t e;
        wr_t o;
        e.addr = 12'h000; e.data = 16'h1111; e.lat = 32'd1;
        exp_q.push_back(e);
        send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        locked = 1'b0;
        wait_clks(3);
        n_total++; if (bus.cpu_run !== 1'b1 || bus.busy !== 1'b0 || bus.err !== 1'b0)
            $display("FAIL midreset: got run=%b busy=%b err=%b want 1/0/0", bus.cpu_run, bus.busy, bus.err); else n_pass++;
        n_total++; if (bus.fl_address !== 12'h000 || bus.fl_data !== 16'h0000)
            $display("FAIL midreset_bus: got %h/%h want 000/0000", bus.fl_address, bus.fl_data); else n_pass++;
        locked = 1'b1;
        wait_clks(50);
        n_total++; if (bus.cpu_run !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL midreset_release: got run=%b busy=%b want 1/0", bus.cpu_run, bus.busy); else n_pass++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) $display("FAIL midreset_write: got none want %h@%h", e.data, e.addr);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL midreset_write: got %h@%h lat %0d want %h@%h lat %0d",
                                      o.data, o.addr, o.lat, e.data, e.addr, e.lat);
                else n_pass++;
            end
        end
        n_total++; if (obs_q.size() != 0) $display("FAIL midreset_extra: got %0d extra writes want 0", obs_q.size()); else n_pass++;
        obs_q.delete();
    endtask

    initial begin
        locked = 1'b0;
        bus.rx = 1'b1;
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_empty_and_noise();
        test_a5_data();
        test_framing_err();
        test_glitch();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
